chacha_block_core: RTL and testbench

Iterative ChaCha20 block function. It accepts a 16-word initial state (constants, key, counter, nonce), runs ROUNDS rounds at one round per clock, alternating column and diagonal arrangement, and adds the original state to produce one 512-bit keystream block. It sits between the state-assembly logic and the keystream XOR stage, with valid/ready handshakes on both sides.

---
 rtl/chacha_pkg.sv | 28 ++
 rtl/chacha_quarter_round.sv | 21 ++
 rtl/chacha_block_core.sv | 84 ++++++++
 tb/tb_chacha_block_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared widths, constants, round index tables and FSM encoding for the ChaCha block core.
package chacha_pkg;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = 16;

  localparam logic [WORD_W-1:0] CONST_0 = 32'h61707865;
  localparam logic [WORD_W-1:0] CONST_1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] CONST_2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] CONST_3 = 32'h6b206574;

  typedef logic [3:0] idx_t;

  // Entry g*4+k is the state word feeding lane k (a,b,c,d) of quarter-round g.
  localparam idx_t COL_IDX  [16] = '{4'd0, 4'd4, 4'd8,  4'd12, 4'd1, 4'd5, 4'd9,  4'd13,
                                     4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
  localparam idx_t DIAG_IDX [16] = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd1, 4'd6, 4'd11, 4'd12,
                                     4'd2, 4'd7, 4'd8,  4'd13, 4'd3, 4'd4, 4'd9,  4'd14};

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  function automatic idx_t qr_idx(input logic diag, input logic [1:0] g, input logic [1:0] k);
    return diag ? DIAG_IDX[{g, k}] : COL_IDX[{g, k}];
  endfunction

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction
endpackage

// File: rtl/chacha_quarter_round.sv
// Combinational ChaCha quarter round on four 32-bit words; lane 0..3 = a..d.
module chacha_quarter_round
  import chacha_pkg::*;
(
  input  logic [3:0][WORD_W-1:0] qin,
  output logic [3:0][WORD_W-1:0] qout
);
  logic [WORD_W-1:0] a, b, c, d;

  always_comb begin
    a = qin[0];
    b = qin[1];
    c = qin[2];
    d = qin[3];
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    qout = {d, c, b, a};
  end
endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one round per clock, then feed-forward add of the input state.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS = 20  // even, >= 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [511:0] BLOCK_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [511:0] BLOCK_o
);
  localparam int               CNT_W    = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_e                          state;
  logic [CNT_W-1:0]                rnd_cnt;
  logic [N_WORDS-1:0][WORD_W-1:0]  work, saved, work_nxt;
  logic [3:0][3:0][WORD_W-1:0]     qr_in, qr_out;

  // Odd rounds gather along diagonals; the result is scattered back so work stays in column order.
  always_comb begin
    qr_in = '0;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        qr_in[g][k] = work[qr_idx(rnd_cnt[0], 2'(g), 2'(k))];
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarter_round u_qr (
      .qin  (qr_in[g]),
      .qout (qr_out[g])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++)
        work_nxt[qr_idx(rnd_cnt[0], 2'(g), 2'(k))] = qr_out[g][k];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      BLOCK_o     <= '0;
      work        <= '0;
      saved       <= '0;
      rnd_cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          work       <= BLOCK_i;
          saved      <= BLOCK_i;
          rnd_cnt    <= '0;
          in_ready_o <= 1'b0;
          state      <= ROUND;
        end
        ROUND: begin
          work    <= work_nxt;
          rnd_cnt <= rnd_cnt + CNT_W'(1);
          if (rnd_cnt == LAST_RND) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < N_WORDS; i++)
            BLOCK_o[i*WORD_W +: WORD_W] <= work[i] + saved[i];
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench: ChaCha20 and ChaCha8 cores against a word-array reference model.
module tb_chacha_block_core;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [511:0] blk_in, blk_out;
  logic         in8_valid, in8_ready, out8_valid, out8_ready;
  logic [511:0] blk8_in, blk8_out;
  logic [3:0][31:0] qr_in, qr_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chacha_block_core #(.ROUNDS(20)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .BLOCK_i(blk_in), .out_valid_o(out_valid), .out_ready_i(out_ready), .BLOCK_o(blk_out));

  chacha_block_core #(.ROUNDS(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in8_valid), .in_ready_o(in8_ready),
    .BLOCK_i(blk8_in), .out_valid_o(out8_valid), .out_ready_i(out8_ready), .BLOCK_o(blk8_out));

  chacha_quarter_round u_qr (.qin(qr_in), .qout(qr_out));

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_model(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = rl(d, 16);
    c += d; b ^= c; b = rl(b, 12);
    a += b; d ^= a; d = rl(d, 8);
    c += d; b ^= c; b = rl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_model(input logic [511:0] blk, input int rounds);
    int cols [4][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15}};
    int diag [4][4] = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    logic [31:0] x [16];
    logic [127:0] r;
    logic [511:0] res;
    int t [4];
    for (int i = 0; i < 16; i++) x[i] = blk[i*32 +: 32];
    for (int n = 0; n < rounds; n++)
      for (int g = 0; g < 4; g++) begin
        for (int k = 0; k < 4; k++) t[k] = (n % 2 == 0) ? cols[g][k] : diag[g][k];
        r = qr_model(x[t[0]], x[t[1]], x[t[2]], x[t[3]]);
        {x[t[0]], x[t[1]], x[t[2]], x[t[3]]} = r;
      end
    for (int i = 0; i < 16; i++) res[i*32 +: 32] = x[i] + blk[i*32 +: 32];
    return res;
  endfunction

  function automatic logic [511:0] rfc_state();
    logic [511:0] s;
    s[0 +: 32] = 32'h61707865; s[32 +: 32] = 32'h3320646e;
    s[64 +: 32] = 32'h79622d32; s[96 +: 32] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      s[(4+i)*32 +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    s[12*32 +: 32] = 32'h00000001; s[13*32 +: 32] = 32'h09000000;
    s[14*32 +: 32] = 32'h4a000000; s[15*32 +: 32] = 32'h00000000;
    return s;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents blk until in_ready, leaves us 1ns after the accept edge with in_valid low.
  task automatic accept(input logic [511:0] blk, output bit ok);
    ok = 1'b0;
    blk_in = blk; in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Edges from now until out_valid is seen; 200 means it never came.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin tick(); cyc++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; blk_in = '0;
    in8_valid = 1'b0; out8_ready = 1'b1; blk8_in = '0;
    repeat (3) tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || blk_out !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b blk_out_nz=%b, want 1 0 0",
               in_ready, out_valid, |blk_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_quarter_round();
    logic [127:0] exp = {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb};
    logic [127:0] got;
    qr_in = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};
    #1;
    got = {qr_out[0], qr_out[1], qr_out[2], qr_out[3]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL quarter_round: got %h want %h", got, exp);
    end
    for (int n = 0; n < 4; n++) begin
      qr_in = {$urandom, $urandom, $urandom, $urandom};
      #1;
      got = {qr_out[0], qr_out[1], qr_out[2], qr_out[3]};
      exp = qr_model(qr_in[0], qr_in[1], qr_in[2], qr_in[3]);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL quarter_round_rand: got %h want %h", got, exp);
      end
    end
  endtask

  task automatic test_rfc_vector();
    logic [127:0] lo_exp = {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    logic [127:0] hi_exp = {32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5};
    bit ok; int cyc;
    out_ready = 1'b1;
    accept(rfc_state(), ok);
    wait_out(cyc);
    // The accept edge starts cycle 1; out_valid is visible in cycle ROUNDS+2 = 22.
    n_checks++;
    if (!ok || cyc !== 21) begin
      n_fail++;
      $display("FAIL rfc_latency: accepted=%0d edges_to_valid=%0d want 21", ok, cyc);
    end
    n_checks++;
    if (blk_out[127:0] !== lo_exp) begin
      n_fail++;
      $display("FAIL rfc_words0_3: got %h want %h", blk_out[127:0], lo_exp);
    end
    n_checks++;
    if (blk_out[511:384] !== hi_exp) begin
      n_fail++;
      $display("FAIL rfc_words12_15: got %h want %h", blk_out[511:384], hi_exp);
    end
    n_checks++;
    if (out_valid && in_ready) begin
      n_fail++;
      $display("FAIL rfc_exclusive: in_ready and out_valid both 1");
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [511:0] blk = rand_block();
    logic [511:0] hold;
    bit ok; int cyc; int bad = 0;
    out_ready = 1'b0;
    accept(blk, ok);
    wait_out(cyc);
    hold = blk_out;
    n_checks++;
    if (hold !== chacha_model(blk, 20)) begin
      n_fail++;
      $display("FAIL backpressure_value: got %h want %h", hold, chacha_model(blk, 20));
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || blk_out !== hold) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_input();
    bit ok; int cyc; int bad = 0;
    out_ready = 1'b1;
    accept(rfc_state(), ok);
    for (int i = 0; i < 15; i++) begin
      in_valid = ~in_valid;
      blk_in   = rand_block();
      if (in_ready !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_ready: in_ready high %0d times during ROUND, want 0", bad);
    end
    wait_out(cyc);
    n_checks++;
    if (blk_out !== chacha_model(rfc_state(), 20)) begin
      n_fail++;
      $display("FAIL busy_value: got %h want %h", blk_out, chacha_model(rfc_state(), 20));
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL busy_extra_block: out_valid high %0d cycles, want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    logic [511:0] blk = rand_block();
    bit ok; int cyc;
    out_ready = 1'b1;
    accept(rfc_state(), ok);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_out !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b blk_out_nz=%b want 0 1 0",
               out_valid, in_ready, |blk_out);
    end
    accept(blk, ok);
    wait_out(cyc);
    n_checks++;
    if (cyc !== 21 || blk_out !== chacha_model(blk, 20)) begin
      n_fail++;
      $display("FAIL mid_reset_recover: edges=%0d got %h want %h", cyc, blk_out, chacha_model(blk, 20));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [511:0] b1 = rand_block();
    logic [511:0] b2 = rand_block();
    bit ok; int cyc;
    out_ready = 1'b1;
    accept(b1, ok);
    in_valid = 1'b1; blk_in = b2;
    wait_out(cyc);
    n_checks++;
    if (blk_out !== chacha_model(b1, 20)) begin
      n_fail++;
      $display("FAIL b2b_first: got %h want %h", blk_out, chacha_model(b1, 20));
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: in_ready=%b want 0", in_ready);
    end
    wait_out(cyc);
    n_checks++;
    if (cyc !== 21 || blk_out !== chacha_model(b2, 20)) begin
      n_fail++;
      $display("FAIL b2b_second: edges=%0d got %h want %h", cyc, blk_out, chacha_model(b2, 20));
    end
    tick();
  endtask

  task automatic test_random();
    logic [511:0] blk;
    bit ok; int cyc;
    for (int n = 0; n < 4; n++) begin
      blk = rand_block();
      out_ready = 1'b0;
      accept(blk, ok);
      wait_out(cyc);
      repeat ($urandom_range(0, 3)) tick();
      n_checks++;
      if (blk_out !== chacha_model(blk, 20)) begin
        n_fail++;
        $display("FAIL random_block%0d: got %h want %h", n, blk_out, chacha_model(blk, 20));
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_rounds8();
    logic [511:0] blk;
    int cyc;
    out8_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      blk = (n == 0) ? rfc_state() : rand_block();
      blk8_in = blk; in8_valid = 1'b1;
      cyc = 0;
      while (!in8_ready && cyc < 100) begin tick(); cyc++; end
      tick();
      in8_valid = 1'b0;
      cyc = 0;
      while (!out8_valid && cyc < 200) begin tick(); cyc++; end
      n_checks++;
      if (cyc !== 9 || blk8_out !== chacha_model(blk, 8)) begin
        n_fail++;
        $display("FAIL rounds8_block%0d: edges=%0d got %h want %h", n, cyc, blk8_out, chacha_model(blk, 8));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_quarter_round();
    test_rfc_vector();
    test_backpressure();
    test_busy_input();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_rounds8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
